svc_axil_router_wr: RTL and testbench



---
 rtl/svc_axil_pkg.sv | 19 +
 rtl/svc_axil_router_sel.sv | 33 +++
 rtl/svc_axil_router_wr.sv | 180 ++++++++++++++++++
 tb/tb_svc_axil_router_wr.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svc_axil_pkg.sv
// Shared AXI-Lite definitions for the svc interconnect routers.
// Holds response codes, router FSM states and a select-width helper.
package svc_axil_pkg;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXIL_RESP_DECERR = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } rtr_state_t;

    // A single-port router still needs a 1-bit select field.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/svc_axil_router_sel.sv
// Address decode shared by the AXI-Lite read and write routers.
// Ports: addr (in) -> sel (port index), bad (no such port), addr_out (stripped).
module svc_axil_router_sel
    import svc_axil_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int OUT_W  = 28,
    parameter int NUM_S  = 2,
    parameter int SEL_W  = sel_width(NUM_S)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [SEL_W-1:0]  sel,
    output logic              bad,
    output logic [OUT_W-1:0]  addr_out
);

    localparam int LOW_W = ADDR_W - SEL_W;

    logic [SEL_W:0]   sel_ext;
    logic [LOW_W-1:0] low;
    logic             unused_addr;

    assign sel     = addr[ADDR_W-1 -: SEL_W];
    // One extra bit keeps the compare meaningful when NUM_S is a power of two.
    assign sel_ext = {1'b0, sel};
    assign bad     = (sel_ext >= NUM_S[SEL_W:0]);
    assign low     = addr[LOW_W-1:0];
    assign addr_out = OUT_W'(low);

    // Upper low-part bits may be dropped when OUT_W < LOW_W.
    assign unused_addr = ^addr;

endmodule

// File: rtl/svc_axil_router_wr.sv
// AXI-Lite write router: one manager to NUM_S subordinates, one txn at a time.
// Ports: clk/rst, s_axil_aw*/w*/b* upstream, m_axil_aw*/w*/b* per-port (flattened).
// Unmapped select values get a local DECERR. Define SVC_AXIL_ROUTER_WR_ASSERT_EN
// to compile in protocol assertions.
module svc_axil_router_wr
    import svc_axil_pkg::*;
#(
    parameter int S_AXIL_ADDR_WIDTH = 32,
    parameter int S_AXIL_DATA_WIDTH = 32,
    parameter int M_AXIL_ADDR_WIDTH = 28,
    parameter int M_AXIL_DATA_WIDTH = 32,
    parameter int NUM_S             = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,

    input  logic                                   s_axil_awvalid,
    output logic                                   s_axil_awready,
    input  logic [S_AXIL_ADDR_WIDTH-1:0]           s_axil_awaddr,
    input  logic                                   s_axil_wvalid,
    output logic                                   s_axil_wready,
    input  logic [S_AXIL_DATA_WIDTH-1:0]           s_axil_wdata,
    input  logic [S_AXIL_DATA_WIDTH/8-1:0]         s_axil_wstrb,
    output logic                                   s_axil_bvalid,
    input  logic                                   s_axil_bready,
    output logic [1:0]                             s_axil_bresp,

    output logic [NUM_S-1:0]                       m_axil_awvalid,
    input  logic [NUM_S-1:0]                       m_axil_awready,
    output logic [NUM_S*M_AXIL_ADDR_WIDTH-1:0]     m_axil_awaddr,
    output logic [NUM_S-1:0]                       m_axil_wvalid,
    input  logic [NUM_S-1:0]                       m_axil_wready,
    output logic [NUM_S*M_AXIL_DATA_WIDTH-1:0]     m_axil_wdata,
    output logic [NUM_S*M_AXIL_DATA_WIDTH/8-1:0]   m_axil_wstrb,
    input  logic [NUM_S-1:0]                       m_axil_bvalid,
    output logic [NUM_S-1:0]                       m_axil_bready,
    input  logic [NUM_S*2-1:0]                     m_axil_bresp
);

    localparam int SEL_W   = sel_width(NUM_S);
    localparam int MAW     = M_AXIL_ADDR_WIDTH;
    localparam int MDW     = M_AXIL_DATA_WIDTH;
    localparam int MSTRB_W = M_AXIL_DATA_WIDTH / 8;

    rtr_state_t            state, state_nx;
    logic                  active;
    logic [SEL_W-1:0]      dec_sel, sel_q;
    logic                  dec_bad, bad_q;
    logic [MAW-1:0]        dec_addr;
    logic                  w_pending, err_bvalid, awready_q, aw_take, w_hs;
    logic [NUM_S-1:0]      awvalid_q;
    logic [NUM_S*MAW-1:0]  awaddr_q;
    logic [MDW-1:0]        wdata_m;
    logic [MSTRB_W-1:0]    wstrb_m;
    logic                  unused_w;

    svc_axil_router_sel #(
        .ADDR_W (S_AXIL_ADDR_WIDTH),
        .OUT_W  (MAW),
        .NUM_S  (NUM_S),
        .SEL_W  (SEL_W)
    ) u_sel (
        .addr     (s_axil_awaddr),
        .sel      (dec_sel),
        .bad      (dec_bad),
        .addr_out (dec_addr)
    );

    assign active  = (state == ST_ACTIVE);
    assign aw_take = !active && s_axil_awvalid;
    assign w_hs    = s_axil_wvalid && s_axil_wready;

    assign wdata_m  = MDW'(s_axil_wdata);
    assign wstrb_m  = MSTRB_W'(s_axil_wstrb);
    assign unused_w = ^{s_axil_wdata, s_axil_wstrb};

    assign s_axil_awready = awready_q;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_awaddr  = awaddr_q;
    // Data is broadcast; only the selected port's wvalid qualifies it.
    assign m_axil_wdata   = {NUM_S{wdata_m}};
    assign m_axil_wstrb   = {NUM_S{wstrb_m}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        m_axil_wvalid = '0;
        m_axil_bready = '0;
        s_axil_wready = 1'b0;
        s_axil_bvalid = 1'b0;
        s_axil_bresp  = AXIL_RESP_OKAY;
        unique case (state)
            ST_IDLE: begin
                if (s_axil_awvalid) begin
                    state_nx = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (bad_q) begin
                    // Sink the data, then answer locally.
                    s_axil_wready = w_pending;
                    s_axil_bvalid = err_bvalid;
                    if (err_bvalid) begin
                        s_axil_bresp = AXIL_RESP_DECERR;
                    end
                end else begin
                    m_axil_wvalid[sel_q] = w_pending && s_axil_wvalid;
                    s_axil_wready = w_pending && m_axil_wready[sel_q];
                    s_axil_bvalid = m_axil_bvalid[sel_q];
                    s_axil_bresp  = m_axil_bresp[int'(sel_q)*2 +: 2];
                    m_axil_bready[sel_q] = s_axil_bready;
                end
                if (s_axil_bvalid && s_axil_bready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q      <= '0;
            bad_q      <= 1'b0;
            w_pending  <= 1'b0;
            err_bvalid <= 1'b0;
            awready_q  <= 1'b0;
            awvalid_q  <= '0;
            awaddr_q   <= '0;
        end else begin
            awready_q <= aw_take;
            for (int i = 0; i < NUM_S; i++) begin
                if (m_axil_awready[i]) begin
                    awvalid_q[i] <= 1'b0;
                end
            end
            if (aw_take) begin
                sel_q      <= dec_sel;
                bad_q      <= dec_bad;
                w_pending  <= 1'b1;
                err_bvalid <= 1'b0;
                if (!dec_bad) begin
                    awvalid_q[dec_sel] <= 1'b1;
                    awaddr_q[int'(dec_sel)*MAW +: MAW] <= dec_addr;
                end
            end else begin
                if (w_hs) begin
                    w_pending <= 1'b0;
                    if (bad_q) begin
                        err_bvalid <= 1'b1;
                    end
                end
                if (bad_q && err_bvalid && s_axil_bready) begin
                    err_bvalid <= 1'b0;
                end
            end
        end
    end

`ifdef SVC_AXIL_ROUTER_WR_ASSERT_EN
    a_no_aw_active: assert property (@(posedge clk) disable iff (rst)
        (active && !s_axil_awready) |=> !s_axil_awready);
    a_awv_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(m_axil_awvalid));
    a_wv_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(m_axil_wvalid));
    a_bvalid_hold: assert property (@(posedge clk) disable iff (rst)
        (s_axil_bvalid && !s_axil_bready) |=> s_axil_bvalid);
    a_bresp_hold: assert property (@(posedge clk) disable iff (rst)
        (s_axil_bvalid && !s_axil_bready) |=> $stable(s_axil_bresp));
`endif

endmodule

// File: tb/tb_svc_axil_router_wr.sv
// Self-checking bench for svc_axil_router_wr (3 ports, 30/32 up, 26/24 down).
module tb_svc_axil_router_wr;

    localparam int SAW = 30;
    localparam int SDW = 32;
    localparam int MAW = 26;
    localparam int MDW = 24;
    localparam int NS  = 3;

    logic                 clk;
    logic                 rst;
    logic                 s_axil_awvalid, s_axil_awready;
    logic [SAW-1:0]       s_axil_awaddr;
    logic                 s_axil_wvalid, s_axil_wready;
    logic [SDW-1:0]       s_axil_wdata;
    logic [SDW/8-1:0]     s_axil_wstrb;
    logic                 s_axil_bvalid, s_axil_bready;
    logic [1:0]           s_axil_bresp;
    logic [NS-1:0]        m_axil_awvalid, m_axil_awready;
    logic [NS*MAW-1:0]    m_axil_awaddr;
    logic [NS-1:0]        m_axil_wvalid, m_axil_wready;
    logic [NS*MDW-1:0]    m_axil_wdata;
    logic [NS*MDW/8-1:0]  m_axil_wstrb;
    logic [NS-1:0]        m_axil_bvalid, m_axil_bready;
    logic [NS*2-1:0]      m_axil_bresp;

    int checks = 0;
    int failures = 0;

    svc_axil_router_wr #(
        .S_AXIL_ADDR_WIDTH (SAW),
        .S_AXIL_DATA_WIDTH (SDW),
        .M_AXIL_ADDR_WIDTH (MAW),
        .M_AXIL_DATA_WIDTH (MDW),
        .NUM_S             (NS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_bresp   (s_axil_bresp),
        .m_axil_awvalid (m_axil_awvalid),
        .m_axil_awready (m_axil_awready),
        .m_axil_awaddr  (m_axil_awaddr),
        .m_axil_wvalid  (m_axil_wvalid),
        .m_axil_wready  (m_axil_wready),
        .m_axil_wdata   (m_axil_wdata),
        .m_axil_wstrb   (m_axil_wstrb),
        .m_axil_bvalid  (m_axil_bvalid),
        .m_axil_bready  (m_axil_bready),
        .m_axil_bresp   (m_axil_bresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the router and what is still owed.
    logic           mact, mbad, mwp, maw, merr, mawrdy;
    logic [1:0]     mport;
    logic [SAW-1:0] maddr;

    function automatic logic e_wready();
        return mact && mwp && (mbad || m_axil_wready[mport]);
    endfunction

    function automatic logic e_bvalid();
        if (!mact) return 1'b0;
        if (mbad) return merr;
        return m_axil_bvalid[mport];
    endfunction

    function automatic logic [1:0] e_bresp();
        if (mbad) return 2'b11;
        return m_axil_bresp[int'(mport)*2 +: 2];
    endfunction

    function automatic logic [NS-1:0] e_awv();
        logic [NS-1:0] v = '0;
        if (maw && !mbad) v[mport] = 1'b1;
        return v;
    endfunction

    function automatic logic [NS-1:0] e_wv();
        logic [NS-1:0] v = '0;
        if (mact && !mbad && mwp && s_axil_wvalid) v[mport] = 1'b1;
        return v;
    endfunction

    function automatic logic [NS-1:0] e_br();
        logic [NS-1:0] v = '0;
        if (mact && !mbad && s_axil_bready) v[mport] = 1'b1;
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mact <= 1'b0; mbad <= 1'b0; mwp <= 1'b0; maw <= 1'b0;
            merr <= 1'b0; mawrdy <= 1'b0; mport <= '0; maddr <= '0;
        end else begin
            mawrdy <= 1'b0;
            if (!mact) begin
                if (s_axil_awvalid) begin
                    mact   <= 1'b1;
                    mwp    <= 1'b1;
                    mawrdy <= 1'b1;
                    merr   <= 1'b0;
                    maddr  <= s_axil_awaddr;
                    mport  <= 2'(s_axil_awaddr >> 28);
                    mbad   <= (s_axil_awaddr >> 28) >= NS;
                    maw    <= (s_axil_awaddr >> 28) < NS;
                end
            end else begin
                if (maw && !mbad && m_axil_awready[mport]) maw <= 1'b0;
                if (e_wready() && s_axil_wvalid) begin
                    mwp <= 1'b0;
                    if (mbad) merr <= 1'b1;
                end
                if (e_bvalid() && s_axil_bready) begin
                    mact <= 1'b0;
                    merr <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("c_awready", s_axil_awready, mawrdy);
            chk("c_awvalid", m_axil_awvalid, e_awv());
            chk("c_wready", s_axil_wready, e_wready());
            chk("c_wvalid", m_axil_wvalid, e_wv());
            chk("c_bvalid", s_axil_bvalid, e_bvalid());
            chk("c_bready", m_axil_bready, e_br());
            if (e_bvalid()) chk("c_bresp", s_axil_bresp, e_bresp());
            if (maw && !mbad)
                chk("c_awaddr", m_axil_awaddr[int'(mport)*MAW +: MAW],
                    maddr % (1 << MAW));
            if (e_wv() != '0) begin
                chk("c_wdata", m_axil_wdata[int'(mport)*MDW +: MDW],
                    s_axil_wdata % (1 << MDW));
                chk("c_wstrb", m_axil_wstrb[int'(mport)*3 +: 3],
                    s_axil_wstrb % 8);
            end
        end
    end

    task automatic do_wr(input int port_i, input logic [SAW-1:0] addr,
                         input logic [SDW-1:0] data, input logic [1:0] sresp,
                         input logic [1:0] exp_resp, input logic [MAW-1:0] exp_addr,
                         input logic [MDW-1:0] exp_data, input int early,
                         input int hold);
        bit aw_done = 0;
        bit w_done = 0;
        int n = 0;
        s_axil_awaddr = addr;
        s_axil_wdata  = data;
        s_axil_wstrb  = 4'hF;
        if (early != 0) begin
            s_axil_wvalid = 1'b1;
            repeat (2) begin
                @(negedge clk);
                chk("early_wready", s_axil_wready, 1'b0);
                @(posedge clk); #1;
            end
        end
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        while (!(aw_done && w_done) && n < 8) begin
            @(negedge clk);
            if (s_axil_awvalid && s_axil_awready) begin
                aw_done = 1;
                chk("aw_lat", n, 1);
                if (port_i >= 0)
                    chk("awaddr", m_axil_awaddr[port_i*MAW +: MAW], exp_addr);
            end
            if (s_axil_wvalid && s_axil_wready) begin
                w_done = 1;
                chk("w_after_aw", aw_done, 1'b1);
                if (port_i >= 0)
                    chk("wdata", m_axil_wdata[port_i*MDW +: MDW], exp_data);
            end
            @(posedge clk); #1;
            if (aw_done) s_axil_awvalid = 1'b0;
            if (w_done) s_axil_wvalid = 1'b0;
            n++;
        end
        if (!(aw_done && w_done)) begin
            chk("hs_timeout", {aw_done, w_done}, 2'b11);
            s_axil_awvalid = 1'b0;
            s_axil_wvalid  = 1'b0;
        end
        if (port_i >= 0) begin
            m_axil_bvalid[port_i] = 1'b1;
            m_axil_bresp[port_i*2 +: 2] = sresp;
        end
        if (hold > 0) begin
            s_axil_awvalid = 1'b1;
            s_axil_awaddr  = '0;
        end
        for (int k = 0; k <= hold; k++) begin
            if (k == hold) begin
                s_axil_bready  = 1'b1;
                s_axil_awvalid = 1'b0;
            end
            @(negedge clk);
            chk("bvalid", s_axil_bvalid, 1'b1);
            chk("bresp", s_axil_bresp, exp_resp);
            if (hold > 0) chk("aw_blocked", s_axil_awready, 1'b0);
            @(posedge clk); #1;
        end
        s_axil_bready = 1'b0;
        m_axil_bvalid = '0;
        @(negedge clk);
        chk("b_drop", s_axil_bvalid, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        s_axil_awvalid = 1'b0; s_axil_awaddr = '0;
        s_axil_wvalid = 1'b0;  s_axil_wdata = '0; s_axil_wstrb = '0;
        s_axil_bready = 1'b0;
        m_axil_awready = '1; m_axil_wready = '1;
        m_axil_bvalid = '0;  m_axil_bresp = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_bvalid", s_axil_bvalid, 1'b0);
        chk("rst_awvalid", m_axil_awvalid, 3'b000);
        chk("rst_wvalid", m_axil_wvalid, 3'b000);
        chk("rst_awready", s_axil_awready, 1'b0);
        chk("rst_wready", s_axil_wready, 1'b0);
        chk("rst_awaddr", m_axil_awaddr, 78'h0);
        chk("rst_bresp", s_axil_bresp, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int s = 0; s < NS; s++)
            do_wr(s, SAW'((s << 28) | 'h1000), 32'h00AB_CD00 + s,
                  2'b00, 2'b00, 26'h1000, 24'hAB_CD00 + s, 0, 0);

        do_wr(0, 30'h0000_2004, 32'h1234_5678, 2'b10, 2'b10,
              26'h2004, 24'h34_5678, 0, 0);

        do_wr(-1, 30'h3FFF_FFFF, 32'hDEAD_BEEF, 2'b00, 2'b11,
              26'h0, 24'h0, 0, 0);

        do_wr(1, 30'h1000_0080, 32'hCAFE_F00D, 2'b00, 2'b00,
              26'h80, 24'hFE_F00D, 1, 0);

        do_wr(2, 30'h2ABC_DEF0, 32'h0102_0304, 2'b00, 2'b00,
              26'h2BC_DEF0, 24'h02_0304, 0, 4);

        do_wr(-1, 30'h3000_0010, 32'h0BAD_0BAD, 2'b00, 2'b11,
              26'h0, 24'h0, 0, 2);

        s_axil_awaddr  = 30'h1000_0040;
        s_axil_awvalid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_awvalid", m_axil_awvalid, 3'b010);
        #1;
        rst = 1'b1;
        s_axil_awvalid = 1'b0;
        #1;
        chk("mid_rst_awvalid", m_axil_awvalid, 3'b000);
        chk("mid_rst_awready", s_axil_awready, 1'b0);
        chk("mid_rst_wready", s_axil_wready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_wr(1, 30'h1000_0100, 32'h5555_AAAA, 2'b00, 2'b00,
              26'h100, 24'h55_AAAA, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
